// File: rtl/branch_check.sv
// branch_check: resolution-side partner of the branch predictor.
//
// Every prediction issued at IF (one per fetched instruction pair) is held in
// an in-order queue. When EX resolves the oldest pair, the actual next PC is
// compared with the recorded prediction. The result is driven back to the
// predictor as training feedback, a front-end redirect is raised on a
// mispredict, and saturating hit/miss statistics are kept.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   pdVld/ifPC/pdPC/pdBranch/pdReason   prediction issued at IF
//   pdReady                   queue not full (combinational from count)
//   rsVld/rsPC/rsNextPC/rsTar/rsType/rsTaken   resolution of the oldest pair
//   flushIn                   external flush (exception/ertn), highest priority
//   exVld/exPC/exPCTar/exType/exBranch/exWrong predictor feedback, 1-cycle latency
//   redirVld/redirPC          front-end redirect on mispredict, 1-cycle latency
//   cntTotal/cntMiss          saturating resolution / mispredict counters

module branch_check #(
    parameter int ADDR_WIDTH  = 32,
    parameter int QUEUE_LOG   = 3,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  pdVld,
    input  logic [ADDR_WIDTH-1:0] ifPC,
    input  logic [ADDR_WIDTH-1:0] pdPC,
    input  logic                  pdBranch,
    input  logic                  pdReason,
    output logic                  pdReady,

    input  logic                  rsVld,
    input  logic [ADDR_WIDTH-1:0] rsPC,
    input  logic [ADDR_WIDTH-1:0] rsNextPC,
    input  logic [ADDR_WIDTH-1:0] rsTar,
    input  logic [1:0]            rsType,
    input  logic                  rsTaken,

    input  logic                  flushIn,

    output logic                  exVld,
    output logic [ADDR_WIDTH-1:0] exPC,
    output logic [ADDR_WIDTH-1:0] exPCTar,
    output logic [1:0]            exType,
    output logic                  exBranch,
    output logic                  exWrong,

    output logic                  redirVld,
    output logic [ADDR_WIDTH-1:0] redirPC,

    output logic [31:0]           cntTotal,
    output logic [31:0]           cntMiss
);

    localparam int                  CW          = QUEUE_LOG + 1;
    localparam logic [CW-1:0]       LP_FULL     = CW'(QUEUE_DEPTH);
    localparam logic [QUEUE_LOG-1:0] LP_PTR_ONE = QUEUE_LOG'(1);

    logic [ADDR_WIDTH-1:0] r_pred_next   [QUEUE_DEPTH];
    logic                  r_pred_br     [QUEUE_DEPTH];
    logic                  r_pred_reason [QUEUE_DEPTH];

    logic [QUEUE_LOG-1:0]  r_head;
    logic [QUEUE_LOG-1:0]  r_tail;
    logic [CW-1:0]         r_count;

    logic [ADDR_WIDTH-4:0] w_fall_hi;
    logic [ADDR_WIDTH-1:0] w_pred_next;
    logic                  w_pop;
    logic                  w_mispredict;
    logic                  w_push;
    logic                  w_clear;
    logic                  w_unused;

    // Fall-through is the next aligned pair; the upper bits wrap naturally.
    assign w_fall_hi   = ifPC[ADDR_WIDTH-1:3] + (ADDR_WIDTH-3)'(1);
    assign w_pred_next = pdBranch ? pdPC : {w_fall_hi, 3'b000};

    assign pdReady      = (r_count != LP_FULL);
    assign w_pop        = rsVld && (r_count != '0) && !flushIn;
    assign w_mispredict = w_pop && (rsNextPC != r_pred_next[r_head]);
    // A push is refused while full even if a pop frees a slot this cycle,
    // and anything fetched alongside a mispredict is wrong-path.
    assign w_push       = pdVld && pdReady && !flushIn && !w_mispredict;
    assign w_clear      = flushIn || w_mispredict;

    // Recorded but not consulted by the check; kept for debug visibility.
    assign w_unused = ^{ifPC[2:0], r_pred_br[r_head], r_pred_reason[r_head]};

    // Entry storage needs no reset: validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pred_next[r_tail]   <= w_pred_next;
            r_pred_br[r_tail]     <= pdBranch;
            r_pred_reason[r_tail] <= pdReason;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + LP_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exVld    <= 1'b0;
            exPC     <= '0;
            exPCTar  <= '0;
            exType   <= '0;
            exBranch <= 1'b0;
            exWrong  <= 1'b0;
            redirVld <= 1'b0;
            redirPC  <= '0;
        end else begin
            exVld    <= w_pop;
            redirVld <= w_mispredict;
            if (w_pop) begin
                exPC     <= rsPC;
                exPCTar  <= rsTar;
                exType   <= rsType;
                exBranch <= rsTaken;
                exWrong  <= w_mispredict;
            end
            if (w_mispredict) begin
                redirPC <= rsNextPC;
            end
        end
    end

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cntTotal <= '0;
            cntMiss  <= '0;
        end else begin
            if (w_pop && (cntTotal != '1)) begin
                cntTotal <= cntTotal + 32'd1;
            end
            if (w_mispredict && (cntMiss != '1)) begin
                cntMiss <= cntMiss + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_check.md
Name: branch_check

Overview:
- Resolution-side counterpart of the branch predictor.
- Records every prediction issued at IF (one entry per fetched instruction pair) in an in-order queue.
- When EX resolves the pair, compares the actual next PC against the recorded prediction.
- Drives the predictor's training/feedback interface (exVld/exPC/exPCTar/exType/exBranch/exWrong) and a front-end redirect, and keeps saturating hit/miss statistics.

Parameters:
ADDR_WIDTH, 32, address width.
QUEUE_LOG, 3, log2 of queue depth.
QUEUE_DEPTH, 8, in-flight prediction entries; must equal 2**QUEUE_LOG.

Ports:
clk  in  1  clock.
rstn  in  1  reset; asynchronous, active-low.
pdVld  in  1  prediction issued this cycle.
ifPC  in  ADDR_WIDTH  PC of the predicted pair.
pdPC  in  ADDR_WIDTH  predicted next PC.
pdBranch  in  1  predicted taken.
pdReason  in  1  slot responsible (0 lower, 1 upper).
pdReady  out  1  queue can accept (not full).
rsVld  in  1  EX resolved the oldest pair.
rsPC  in  ADDR_WIDTH  PC of the deciding instruction.
rsNextPC  in  ADDR_WIDTH  actual next PC of the pair.
rsTar  in  ADDR_WIDTH  branch target of the deciding instruction.
rsType  in  2  instruction type.
rsTaken  in  1  actually taken.
flushIn  in  1  external flush (exception/ertn).
exVld, exPC, exPCTar, exType, exBranch, exWrong  out  1/AW/AW/2/1/1  predictor feedback, registered.
redirVld  out  1  redirect front end.
redirPC  out  ADDR_WIDTH  redirect target.
cntTotal, cntMiss  out  32 each  statistics.

Behaviour:
- Reset (async, rstn=0): queue empty, head=tail=count=0; all outputs 0 except pdReady=1; counters 0.
- Entry contents: {predNext, pdBranch, pdReason}.
  - predNext = pdBranch ? pdPC : {ifPC[AW-1:3]+1, 3'b000}.
  - Fall-through wraps modulo 2**AW.
- Push: on the clk edge when pdVld && pdReady && !flushIn && !mispredict-this-cycle; write at tail, tail++ (wraps mod QUEUE_DEPTH).
- pdReady = (count != QUEUE_DEPTH), combinational from count.
  - When full, a push is refused even if a pop occurs the same cycle.
- Pop: on the edge when rsVld && count!=0 && !flushIn; read head, head++.
  - rsVld with empty queue is ignored: no feedback, no counter change.
  - No push-to-pop bypass: an entry pushed in cycle N is poppable from N+1.
- Compare (combinational on pop): mispredict = (rsNextPC != head.predNext).
  - pdReason is not part of the check.
- Feedback, 1-cycle latency (registered at the pop edge):
  - exVld=1, exPC=rsPC, exPCTar=rsTar, exType=rsType, exBranch=rsTaken, exWrong=mispredict.
  - exVld is a single-cycle pulse per pop; 0 otherwise.
- Redirect: redirVld=mispredict and redirPC=rsNextPC, registered with the same latency, single-cycle pulse.
- On mispredict:
  - Queue cleared at that edge: head=tail, count=0; all younger entries are wrong-path.
  - A push in the same cycle is dropped.
- flushIn (any cycle, highest priority):
  - Queue cleared; push and pop suppressed; exVld and redirVld are 0 next cycle.
  - A pending registered feedback from the previous cycle still appears (already registered).
- Count: count_next = count + push - pop, or 0 on clear. Never exceeds QUEUE_DEPTH or goes below 0.
- Statistics: cntTotal++ per pop, cntMiss++ per mispredicting pop; both saturate at 32'hFFFF_FFFF.
  - Not cleared by flushIn, only by rstn.
- Reset mid-operation: immediate return to reset state; registered pulses are cancelled.

Test Plan:
- Sequential hit: push ifPC=0x1C000000, pdBranch=0; then rsVld, rsNextPC=0x1C000008 -> next cycle exVld=1, exWrong=0, redirVld=0, cntTotal=1, cntMiss=0.
- Taken mispredict with younger entries: push three entries, the first with pdPC=0x1C000100, pdBranch=1. Resolve the first with rsNextPC=0x1C000200 -> exWrong=1, redirVld=1, redirPC=0x1C000200, count=0, pdReady=1, cntMiss=1.
- Full queue: push 8 entries -> pdReady=0. A 9th pdVld, with or without a simultaneous pop, is not stored (count stays 8, or goes to 7 with the pop). After draining 8 hits, exactly 8 exVld pulses.
- Empty edge: rsVld with count=0 -> no exVld, counters unchanged. Push and rsVld in the same cycle on an empty queue -> push accepted, pop ignored, count=1.
- flushIn with count=5 plus simultaneous pdVld and rsVld -> count=0, no exVld next cycle, counters unchanged.
- Async reset asserted mid-stream while exVld is pending -> all outputs 0 immediately, pdReady=1, cntTotal=0.
